// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell plus a registered carry, LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.

module full_adder (
  input  logic din_a,
  input  logic din_b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = din_a ^ din_b ^ c_in;
  assign c_out = (din_a & din_b) | (din_a & c_in) | (din_b & c_in);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_sr, b_sr, res_sr;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               fa_sum, fa_c_out;
  logic [WIDTH-1:0]   res_next;
  logic [WIDTH-1:0]   b_load;
  logic               carry_load;
  logic               last_bit;

  full_adder u_fa (
    .din_a (a_sr[0]),
    .din_b (b_sr[0]),
    .c_in  (carry),
    .sum   (fa_sum),
    .c_out (fa_c_out)
  );

  // Subtraction is A + ~B + 1, so only the B and carry loads differ.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~din_b : din_b;
  assign carry_load = sub ? 1'b1 : c_in;
`else
  assign b_load     = din_b;
  assign carry_load = c_in;
`endif

  assign res_next = {fa_sum, res_sr[WIDTH-1:1]};
  assign last_bit = (cnt == CNT_LAST);
  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      c_out  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sr  <= din_a;
            b_sr  <= b_load;
            carry <= carry_load;
            cnt   <= '0;
          end
        end
        RUN: begin
          res_sr <= res_next;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= fa_c_out;
          cnt    <= cnt + CNT_W'(1);
          // Result registers only move on the final bit, so they hold between operations.
          if (last_bit) begin
            sum   <= res_next;
            c_out <= fa_c_out;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
